// File: rtl/filter_pkg.sv
// Shared types and constants for the filtration pump control path.
// The ramp helper is used by every PWM channel to slew applied duty toward its target.
package filter_pkg;

  typedef logic [7:0] duty_t;

  localparam duty_t PWM_MAX  = 8'd230;
  localparam duty_t PWM_MIN  = 8'd77;
  localparam duty_t PWM_FULL = 8'd255;

  localparam logic [7:0] STEP_LAST = 8'd254;

  // Differences are taken 9 bits wide so target/applied near the rails never wrap.
  function automatic duty_t ramp_next(input duty_t applied, input duty_t target,
                                      input logic [8:0] step, input logic down_immediate);
    logic [8:0] delta;
    duty_t      move;
    delta     = '0;
    move      = '0;
    ramp_next = target;
    if (step == 9'd0) begin
      ramp_next = target;
    end else if (target >= applied) begin
      delta     = {1'b0, target} - {1'b0, applied};
      move      = (step < delta) ? duty_t'(step) : duty_t'(delta);
      ramp_next = applied + move;
    end else if (!down_immediate) begin
      delta     = {1'b0, applied} - {1'b0, target};
      move      = (step < delta) ? duty_t'(step) : duty_t'(delta);
      ramp_next = applied - move;
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period-sampled target, soft-start ramp on the applied duty,
// and a registered compare against the shared step counter.
module pwm_channel
  import filter_pkg::*;
#(
  parameter int RAMP_STEP           = 5,
  parameter bit RAMP_DOWN_IMMEDIATE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       boundary,
  input  logic [7:0] step_cnt,
  input  duty_t      duty_cmd,
  output logic       pwm_out,
  output duty_t      applied_duty,
  output logic       at_target
);

  localparam logic [8:0] STEP_CLAMP = (RAMP_STEP > 255) ? 9'd255 : 9'(RAMP_STEP);

  duty_t target_q;

  // Disable clears both duties at once, even if it coincides with a boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q     <= '0;
      applied_duty <= '0;
    end else if (!enable) begin
      target_q     <= '0;
      applied_duty <= '0;
    end else if (boundary) begin
      target_q     <= duty_cmd;
      applied_duty <= ramp_next(applied_duty, duty_cmd, STEP_CLAMP, RAMP_DOWN_IMMEDIATE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= enable && (step_cnt < applied_duty);
    end
  end

  assign at_target = (applied_duty == target_q);

endmodule

// File: rtl/pump_pwm_generator.sv
// Dual-channel pump PWM: shared prescaler/step timebase with a period_start pulse,
// feeding one pwm_channel per pump.
module pump_pwm_generator
  import filter_pkg::*;
#(
  parameter int unsigned PRESCALE_CYCLES     = 8,
  parameter int          RAMP_STEP           = 5,
  parameter bit          RAMP_DOWN_IMMEDIATE = 1'b1
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  pwm_enable,
  input  duty_t pwm_duty_a,
  input  duty_t pwm_duty_b,
  output logic  pwm_out_a,
  output logic  pwm_out_b,
  output duty_t applied_duty_a,
  output duty_t applied_duty_b,
  output logic  at_target_a,
  output logic  at_target_b,
  output logic  period_start
);

  localparam int PRESC_W = (PRESCALE_CYCLES > 1) ? $clog2(PRESCALE_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE_CYCLES - 1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         step_cnt;
  logic               presc_wrap;
  logic               boundary;

  assign presc_wrap = (presc_cnt == PRESC_LAST);
  assign boundary   = presc_wrap && (step_cnt == STEP_LAST);

  // The timebase free-runs regardless of pwm_enable so re-enable lands on a clean period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt    <= '0;
      step_cnt     <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (presc_wrap) begin
        presc_cnt <= '0;
        step_cnt  <= boundary ? 8'd0 : step_cnt + 8'd1;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
    end
  end

  pwm_channel #(
    .RAMP_STEP          (RAMP_STEP),
    .RAMP_DOWN_IMMEDIATE(RAMP_DOWN_IMMEDIATE)
  ) u_chan_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (pwm_enable),
    .boundary    (boundary),
    .step_cnt    (step_cnt),
    .duty_cmd    (pwm_duty_a),
    .pwm_out     (pwm_out_a),
    .applied_duty(applied_duty_a),
    .at_target   (at_target_a)
  );

  pwm_channel #(
    .RAMP_STEP          (RAMP_STEP),
    .RAMP_DOWN_IMMEDIATE(RAMP_DOWN_IMMEDIATE)
  ) u_chan_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (pwm_enable),
    .boundary    (boundary),
    .step_cnt    (step_cnt),
    .duty_cmd    (pwm_duty_b),
    .pwm_out     (pwm_out_b),
    .applied_duty(applied_duty_b),
    .at_target   (at_target_b)
  );

endmodule
